pb_intc: RTL and testbench
==========================

# pb_intc

Programmable interrupt controller for the PicoBlaze peripheral bus. It replaces the plain OR of peripheral interrupt lines in front of the CPU's `interrupt` input. Per source it provides:

- input synchronisation,
- edge or level detection,
- sticky pending bits,
- enable masking,
- a priority vector.

It drives the single CPU `interrupt` line with a handshake against `interrupt_ack`. It is a port-mapped slave on the same `port_id`/`in_port` OR-bus as the other `pb_*` peripherals.

## Interface
- `BASE_ADDRESS`, default `8'h80`: 16-port window. Decode is `port_id[7:4] == BASE_ADDRESS[7:4]`; the offset is `port_id[3:0]`.
- `clk` in, 1: system clock. All logic is rising-edge.
- `reset` in, 1: asynchronous, active-low reset.
- `irq_in` in, 8: raw interrupt sources. Bit 0 is highest priority. Sources may be asynchronous (e.g. `int1`/`int2` pins).
- `port_id` in, 8: CPU port address.
- `data_in` in, 8: CPU `out_port`.
- `write_strobe` in, 1: one-cycle write qualifier.
- `read_strobe` in, 1: one-cycle read qualifier. It has no side effects here.
- `interrupt_ack` in, 1: one-cycle pulse from the CPU on interrupt entry.
- `data_out` out, 8: registered read data. It is `8'h00` whenever not addressed, so it can be OR'd onto `in_port`.
- `interrupt` out, 1: registered interrupt request to the CPU.

## Operation

**Register map (offset):**
- `0` STATUS, R/W1C: pending bits.
- `1` ENABLE, R/W: reset value `8'h00`.
- `2` EDGE, R/W: 1 = rising-edge source, 0 = active-high level source. Reset value `8'hFF`.
- `3` MASKED, R: STATUS & ENABLE.
- `4` VECTOR, R: `{valid, 4'b0, idx[2:0]}`. `idx` is the lowest-numbered set MASKED bit; `valid` = |MASKED. Reads `8'h00` when nothing is masked-pending.
- `5` SET, W: write-1 sets pending bits (software-triggered interrupt). Reads `8'h00`.
- `6`–`F`: reads `8'h00`; writes are ignored.

**Source path:**
- Each `irq_in` bit passes through a 2-flop synchroniser (`s`), then a third history flop (`s_d`).
- Edge source: pending is set when `s & ~s_d`. It is sticky until W1C.
- Level source: pending is set on every cycle that `s` is 1. A W1C only takes effect on cycles where `s` is 0, so effectively the bit re-sets while the level is held.
- Disabled sources still latch pending; ENABLE only masks.

**Pending update priority, per bit and per cycle:**
- Hardware set or SET-register write beats a W1C in the same cycle.
- A W1C of a bit that is not pending has no effect.
- Changing EDGE does not alter existing pending bits.

**Request FSM (`IDLE`, `REQ`, `SERVICE`):**
- `IDLE` → `REQ` when |MASKED. `interrupt` = 1 in `REQ`.
- `REQ` → `SERVICE` on `interrupt_ack`. `interrupt` = 0.
- `REQ` → `IDLE` if MASKED becomes 0 before the ack (source cleared or disabled). `interrupt` falls.
- `SERVICE` → `IDLE` on any write to offset 0 (STATUS). This write is the end-of-interrupt (EOI) event.
- `SERVICE` ignores new pending bits. They are re-evaluated in `IDLE`, so an interrupt that is still pending re-requests.
- `interrupt_ack` in `IDLE` or `SERVICE` is ignored.

**Reset values:** FSM = `IDLE`, `interrupt` = 0, `data_out` = `8'h00`, STATUS = `8'h00`, all synchroniser flops = 0.

## Timing
- `irq_in` edge to pending bit set: 3 clocks (2 synchroniser clocks + 1 register).
- Pending bit set to `interrupt` high: 1 further clock. Total `irq_in` → `interrupt` is 4 clocks when enabled and in `IDLE`.
- Read latency: `data_out` is registered from the `port_id` decode each clock, independent of `read_strobe`. It is valid 1 clock after `port_id` is stable, which meets the KCPSM6 2-cycle input window.
- Writes take effect on the clock edge where `write_strobe` = 1. The MASKED/VECTOR readback reflects a write on the next cycle.
- `interrupt_ack` drops `interrupt` on the next clock edge.
- The EOI write returns the FSM to `IDLE` on that edge. If pending work remains, `interrupt` re-asserts 1 clock later.
- Reset asserted mid-operation forces all state to the reset values asynchronously. Deassertion is synchronous to `clk`; the top level provides this.

## Test plan
1. **Reset defaults.** After reset, read offsets 0–5.
   - Required: `00, 00, FF, 00, 00, 00`; `interrupt` = 0.
2. **Edge source end to end.** ENABLE = `8'h04`; pulse `irq_in[2]` for 1 clock (held ≥ 2 clocks if asynchronous).
   - `interrupt` = 1 exactly 4 clocks later; VECTOR = `8'h82`.
   - `interrupt_ack` → `interrupt` = 0.
   - Write STATUS = `8'h04` → STATUS = `8'h00`; `interrupt` stays 0.
3. **Priority and re-request.** ENABLE = `8'hFF`; set pending bits 5 and 1 via SET = `8'h22`.
   - VECTOR = `8'h81`.
   - Ack, then EOI write STATUS = `8'h02` → `interrupt` re-asserts 1 clock later; VECTOR = `8'h85`.
4. **Level source.** EDGE = `8'h00`, ENABLE = `8'h01`; hold `irq_in[0]` = 1.
   - W1C STATUS bit 0 → reads back `8'h01`.
   - Drop `irq_in[0]`, wait 3 clocks, W1C again → STATUS = `8'h00`.
5. **Collision.** W1C STATUS bit 3 in the same cycle as a synchronised rising edge on `irq_in[3]`.
   - STATUS bit 3 remains 1.
6. **Bus cleanliness and withdrawal.**
   - `port_id` outside the window → `data_out` = `8'h00` throughout.
   - In `REQ`, write ENABLE = `8'h00` → `interrupt` = 0 on the next clock and the FSM returns to `IDLE`.
   - Assert `reset` while in `SERVICE` → `IDLE`, `interrupt` = 0, STATUS = `8'h00`.

Source files
------------

// File: rtl/pb_intc_if.sv
// PicoBlaze port-mapped peripheral bus: CPU address/data/strobes and the
// OR-able registered read return.
interface pb_intc_if;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] data_out;

  modport master (
    output port_id,
    output data_in,
    output write_strobe,
    output read_strobe,
    input  data_out
  );

  modport slave (
    input  port_id,
    input  data_in,
    input  write_strobe,
    input  read_strobe,
    output data_out
  );
endinterface

// File: rtl/pb_intc.sv
// Programmable interrupt controller for the PicoBlaze port bus: synchronised
// edge/level sources, sticky pending bits, enable mask, priority vector, req/ack FSM.
module pb_intc #(
  parameter logic [7:0] BASE_ADDRESS = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic       interrupt_ack,
  output logic       interrupt,
  pb_intc_if.slave   bus
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned OFFW = 4;

  localparam logic [OFFW-1:0] OFF_STATUS = 4'h0;
  localparam logic [OFFW-1:0] OFF_ENABLE = 4'h1;
  localparam logic [OFFW-1:0] OFF_EDGE   = 4'h2;
  localparam logic [OFFW-1:0] OFF_MASKED = 4'h3;
  localparam logic [OFFW-1:0] OFF_VECTOR = 4'h4;
  localparam logic [OFFW-1:0] OFF_SET    = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Source synchroniser and history flops
  logic [NSRC-1:0] sync_meta_q;
  logic [NSRC-1:0] sync_q;
  logic [NSRC-1:0] sync_hist_q;

  // Programmable registers
  logic [NSRC-1:0] status_q,   status_d;
  logic [NSRC-1:0] enable_q,   enable_d;
  logic [NSRC-1:0] edge_sel_q, edge_sel_d;

  logic [7:0]      data_out_q, data_out_d;
  logic            interrupt_q, interrupt_d;
  state_e          state_q,    state_d;

  // Bus decode
  logic            addr_hit_c;
  logic [OFFW-1:0] offset_c;
  logic            wr_status_c;
  logic            wr_enable_c;
  logic            wr_edge_c;
  logic            wr_set_c;

  // Source and mask evaluation
  logic [NSRC-1:0] hw_set_c;
  logic [NSRC-1:0] sw_set_c;
  logic [NSRC-1:0] clr_c;
  logic [NSRC-1:0] masked_c;
  logic            any_masked_c;
  logic [IDXW-1:0] idx_c;
  logic [7:0]      vector_c;

  // Reads have no side effects, so the read qualifier is not needed.
  logic            unused_read_strobe_c;
  assign unused_read_strobe_c = bus.read_strobe;

  always_comb begin
    addr_hit_c  = (bus.port_id[7:4] == BASE_ADDRESS[7:4]);
    offset_c    = bus.port_id[OFFW-1:0];
    wr_status_c = bus.write_strobe && addr_hit_c && (offset_c == OFF_STATUS);
    wr_enable_c = bus.write_strobe && addr_hit_c && (offset_c == OFF_ENABLE);
    wr_edge_c   = bus.write_strobe && addr_hit_c && (offset_c == OFF_EDGE);
    wr_set_c    = bus.write_strobe && addr_hit_c && (offset_c == OFF_SET);
  end

  // Input synchroniser; all flops clear on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      sync_hist_q <= '0;
    end else begin
      sync_meta_q <= irq_in;
      sync_q      <= sync_meta_q;
      sync_hist_q <= sync_q;
    end
  end

  // Set sources always win over a same-cycle W1C, which also keeps a held level re-pending.
  always_comb begin
    hw_set_c   = (edge_sel_q & sync_q & ~sync_hist_q) | (~edge_sel_q & sync_q);
    sw_set_c   = wr_set_c    ? bus.data_in : '0;
    clr_c      = wr_status_c ? bus.data_in : '0;
    status_d   = (status_q & ~clr_c) | hw_set_c | sw_set_c;
    enable_d   = wr_enable_c ? bus.data_in : enable_q;
    edge_sel_d = wr_edge_c   ? bus.data_in : edge_sel_q;
  end

  // Lowest-numbered masked-pending source wins
  always_comb begin
    masked_c     = status_q & enable_q;
    any_masked_c = |masked_c;
    idx_c        = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (masked_c[i]) begin
        idx_c = IDXW'(i);
      end
    end
    vector_c = any_masked_c ? {1'b1, 4'b0000, idx_c} : 8'h00;
  end

  // Read mux returns zero whenever the window is not addressed
  always_comb begin
    data_out_d = 8'h00;
    if (addr_hit_c) begin
      case (offset_c)
        OFF_STATUS: data_out_d = status_q;
        OFF_ENABLE: data_out_d = enable_q;
        OFF_EDGE:   data_out_d = edge_sel_q;
        OFF_MASKED: data_out_d = masked_c;
        OFF_VECTOR: data_out_d = vector_c;
        default:    data_out_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q   <= '0;
      enable_q   <= '0;
      edge_sel_q <= '1;
      data_out_q <= 8'h00;
    end else begin
      status_q   <= status_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      data_out_q <= data_out_d;
    end
  end

  // Request FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
    end
  end

  // Request FSM: next state; the STATUS write is the end-of-interrupt event
  always_comb begin
    state_d     = state_q;
    interrupt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_masked_c) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (interrupt_ack) begin
          state_d = ST_SERVICE;
        end else if (!any_masked_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_status_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    interrupt_d = (state_d == ST_REQ);
  end

  assign interrupt    = interrupt_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_pb_intc.sv
// Directed bench for pb_intc; stimulus pushes expectations, a negedge monitor
// pops and compares read data and the interrupt line.
module tb_pb_intc;

  logic       clk           = 1'b0;
  logic       reset         = 1'b0;
  logic [7:0] irq_in        = 8'h00;
  logic       interrupt_ack = 1'b0;
  logic       interrupt;

  pb_intc_if bus ();

  pb_intc #(.BASE_ADDRESS(8'h80)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .interrupt_ack(interrupt_ack),
    .interrupt    (interrupt),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];

  logic irq_chk = 1'b0;
  logic rd_seen = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  // Read data is valid one clock after the strobe cycle
  always @(posedge clk) rd_seen <= bus.read_strobe;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_seen) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow: read data with no expectation, data_out=%02h", bus.data_out);
      end else begin
        e = rd_q.pop_front();
        if (bus.data_out !== e.exp) begin
          bad++;
          $display("FAIL %s: data_out got %02h want %02h", e.name, bus.data_out, e.exp);
        end
      end
    end
    if (irq_chk) begin
      total++;
      if (irq_q.size() == 0) begin
        bad++;
        $display("FAIL irq_underflow: irq check with no expectation, interrupt=%b", interrupt);
      end else begin
        e = irq_q.pop_front();
        if (interrupt !== e.exp[0]) begin
          bad++;
          $display("FAIL %s: interrupt got %b want %b", e.name, interrupt, e.exp[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.port_id      = a;
    bus.data_in      = d;
    bus.write_strobe = 1'b1;
    cyc();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] expv, input string name);
    exp_t e;
    e.name = name;
    e.exp  = expv;
    rd_q.push_back(e);
    bus.port_id     = a;
    bus.read_strobe = 1'b1;
    cyc();
    bus.read_strobe = 1'b0;
  endtask

  task automatic chk_irq(input logic expv, input string name);
    exp_t e;
    e.name = name;
    e.exp  = {7'b0, expv};
    irq_q.push_back(e);
    irq_chk = 1'b1;
    cyc();
    irq_chk = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.port_id      = 8'h00;
    bus.data_in      = 8'h00;
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset defaults
    rd(8'h80, 8'h00, "rst_status");
    rd(8'h81, 8'h00, "rst_enable");
    rd(8'h82, 8'hFF, "rst_edge");
    rd(8'h83, 8'h00, "rst_masked");
    rd(8'h84, 8'h00, "rst_vector");
    rd(8'h85, 8'h00, "rst_set");
    chk_irq(1'b0, "rst_irq");

    // Edge source end to end: interrupt exactly 4 clocks after irq_in rises
    wr(8'h81, 8'h04);
    irq_in = 8'h04;
    chk_irq(1'b0, "edge_clk1");
    chk_irq(1'b0, "edge_clk2");
    irq_in = 8'h00;
    chk_irq(1'b0, "edge_clk3");
    chk_irq(1'b0, "edge_clk4");
    chk_irq(1'b1, "edge_irq_high");
    rd(8'h84, 8'h82, "edge_vector");
    rd(8'h80, 8'h04, "edge_status");
    ack();
    chk_irq(1'b0, "edge_ack_drop");
    wr(8'h80, 8'h04);
    rd(8'h80, 8'h00, "edge_eoi_status");
    chk_irq(1'b0, "edge_eoi_irq");

    // Priority and re-request after EOI
    wr(8'h81, 8'hFF);
    wr(8'h85, 8'h22);
    rd(8'h84, 8'h81, "prio_vector");
    chk_irq(1'b1, "prio_irq");
    ack();
    chk_irq(1'b0, "prio_ack");
    wr(8'h80, 8'h02);
    chk_irq(1'b0, "prio_eoi_gap");
    chk_irq(1'b1, "prio_rereq");
    rd(8'h84, 8'h85, "prio_rereq_vector");
    ack();
    wr(8'h80, 8'h20);
    rd(8'h80, 8'h00, "prio_clear");

    // Level source: W1C ignored while held, effective once dropped
    wr(8'h82, 8'h00);
    wr(8'h81, 8'h01);
    irq_in = 8'h01;
    repeat (4) cyc();
    chk_irq(1'b1, "level_irq");
    wr(8'h80, 8'h01);
    rd(8'h80, 8'h01, "level_w1c_held");
    irq_in = 8'h00;
    repeat (3) cyc();
    wr(8'h80, 8'h01);
    rd(8'h80, 8'h00, "level_w1c_clear");
    chk_irq(1'b0, "level_irq_drop");
    wr(8'h82, 8'hFF);
    wr(8'h81, 8'h00);

    // Collision: synchronised rising edge in the same cycle as W1C of that bit
    wr(8'h85, 8'h08);
    irq_in = 8'h08;
    cyc();
    cyc();
    wr(8'h80, 8'h08);
    rd(8'h80, 8'h08, "collision_status");
    wr(8'h80, 8'h08);
    rd(8'h80, 8'h00, "collision_clear");
    irq_in = 8'h00;

    // Bus cleanliness with a nonzero pending register
    wr(8'h85, 8'h10);
    rd(8'h40, 8'h00, "bus_out_40");
    rd(8'h00, 8'h00, "bus_out_00");
    rd(8'h90, 8'h00, "bus_out_90");
    rd(8'h88, 8'h00, "bus_unmapped_88");
    rd(8'h80, 8'h10, "bus_in_status");
    rd(8'h84, 8'h00, "bus_vector_none");
    chk_irq(1'b0, "disabled_no_irq");

    // Withdrawal in REQ, then re-request from IDLE
    wr(8'h81, 8'h10);
    chk_irq(1'b0, "withdraw_gap");
    chk_irq(1'b1, "withdraw_req");
    wr(8'h81, 8'h00);
    cyc();
    chk_irq(1'b0, "withdraw_drop");
    wr(8'h81, 8'h10);
    chk_irq(1'b0, "reen_gap");
    chk_irq(1'b1, "reen_req");
    ack();
    chk_irq(1'b0, "svc_irq");

    // Asynchronous reset while in SERVICE
    #3 reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    rd(8'h80, 8'h00, "rst_mid_status");
    rd(8'h81, 8'h00, "rst_mid_enable");
    chk_irq(1'b0, "rst_mid_irq");
    wr(8'h81, 8'h01);
    wr(8'h85, 8'h01);
    chk_irq(1'b0, "post_rst_gap");
    chk_irq(1'b1, "post_rst_req");

    cyc();
    cyc();
    total++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: rd_left=%0d irq_left=%0d want 0", rd_q.size(), irq_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
